// File: rtl/pll_ce_pkg.sv
// pll_ce_pkg: shared state encoding and sizing helpers for the PLL clock-enable sequencer.
package pll_ce_pkg;
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, SETTLE = 2'd1, RUN = 2'd2} seq_state_t;
  localparam int SETTLE_CYC_DEF = 1024;
  localparam int SETTLE_W = $clog2(SETTLE_CYC_DEF);
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pll_ce_acc.sv
// pll_ce_acc: one fractional phase accumulator channel producing ce and (with PLL_CE_HALF_EN) ce_half.
module pll_ce_acc #(
  parameter int ACC_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             run,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             ce,
  output logic             ce_half
);
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             go;
  assign sum = {1'b0, acc} + {1'b0, inc};
  assign go  = run & en;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      ce  <= 1'b0;
    end else begin
      acc <= go ? sum[ACC_W-1:0] : '0;
      ce  <= go & sum[ACC_W];
    end
`ifdef PLL_CE_HALF_EN
  // 180-degree enable: fires when the phase passes the half-way point
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) ce_half <= 1'b0;
    else ce_half <= go & ((~acc[ACC_W-1] & sum[ACC_W-1]) | (sum[ACC_W] & sum[ACC_W-1]));
`else
  assign ce_half = 1'b0;
`endif
endmodule

// File: rtl/pll_ce_sequencer.sv
// pll_ce_sequencer: post-PLL reset sequencer and NUM_CH clock-enable generators.
// Optional half-phase enables are built when PLL_CE_HALF_EN is defined.
module pll_ce_sequencer
  import pll_ce_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = 16,
  parameter int SETTLE_CYC = 1024
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*ACC_W-1:0] ch_inc,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    lost_lock_clr,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       ce_half,
  output logic                    sys_reset_n,
  output logic [1:0]              seq_state,
  output logic                    lost_lock
);
  localparam int CW = cnt_w(SETTLE_CYC);
  seq_state_t state, next_state;
  logic          lk_m, lk_s, run;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      lk_m <= pll_locked;
      lk_s <= lk_m;
    end
  always_comb begin
    next_state = !lk_s ? WAIT_LOCK :
                 state == WAIT_LOCK ? SETTLE :
                 (state == SETTLE && cnt == CW'(SETTLE_CYC - 1)) ? RUN : state;
  end
  // accumulators advance only while staying in RUN, so entry gives a full first period and exit clears at once
  assign run       = (state == RUN) && (next_state == RUN);
  assign seq_state = state;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_reset_n <= 1'b0;
      lost_lock   <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= (state == SETTLE && next_state == SETTLE) ? cnt + 1'b1 : '0;
      sys_reset_n <= next_state == RUN;
      lost_lock   <= (state == RUN && !lk_s) | (lost_lock & ~lost_lock_clr);
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_ce_acc #(.ACC_W(ACC_W)) u_acc (
      .clk_sys(clk_sys),
      .rst_n  (rst_n),
      .run    (run),
      .en     (ch_en[i]),
      .inc    (ch_inc[i*ACC_W +: ACC_W]),
      .ce     (ce[i]),
      .ce_half(ce_half[i])
    );
  end
endmodule

// File: tb/tb_pll_ce_sequencer.sv
// tb_pll_ce_sequencer: randomized scoreboard bench with a lock-streak reference model.
module tb_pll_ce_sequencer;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SC = 16;
  localparam int M  = 1 << W;
  logic clk_sys = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, lost_lock_clr = 1'b0;
  logic [N*W-1:0] ch_inc = '0;
  logic [N-1:0]   ch_en = '0;
  logic [N-1:0]   ce, ce_half;
  logic           sys_reset_n, lost_lock;
  logic [1:0]     seq_state;
  int passed = 0, total = 0;
  logic [11:0] q[$];

  always #5 clk_sys = ~clk_sys;

  pll_ce_sequencer #(.NUM_CH(N), .ACC_W(W), .SETTLE_CYC(SC)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pll_locked(pll_locked), .ch_inc(ch_inc),
    .ch_en(ch_en), .lost_lock_clr(lost_lock_clr), .ce(ce), .ce_half(ce_half),
    .sys_reset_n(sys_reset_n), .seq_state(seq_state), .lost_lock(lost_lock)
  );

  // Model: the lock streak (consecutive synchronised-lock edges) determines the state;
  // each channel's phase is an integer modulo 2^W advanced while staying in RUN.
  int m1, m2, lks, streak, prev, s, inc_c;
  int acc[N];
  bit lost, run_m;
  logic [N-1:0] e_ce, e_half;
  logic [1:0] e_st;
  initial forever begin
    @(posedge clk_sys);
    if (!rst_n) begin
      m1 = 0; m2 = 0; streak = 0; lost = 0;
      for (int c = 0; c < N; c++) acc[c] = 0;
      q.push_back(12'h0);
    end else begin
      lks = m2; m2 = m1; m1 = int'(pll_locked);
      prev = streak;
      streak = (lks != 0) ? ((streak < 1000) ? streak + 1 : streak) : 0;
      run_m = (prev > SC) && (streak > SC);
      lost = ((prev > SC) && (lks == 0)) || (lost && !lost_lock_clr);
      e_ce = '0; e_half = '0;
      for (int c = 0; c < N; c++) begin
        inc_c = int'(ch_inc[c*W +: W]);
        if (run_m && ch_en[c]) begin
          s = acc[c] + inc_c;
          e_ce[c] = (s >= M);
`ifdef PLL_CE_HALF_EN
          e_half[c] = (acc[c] < M/2 && s >= M/2 && s < M) || (s >= M + M/2);
`endif
          acc[c] = s % M;
        end else acc[c] = 0;
      end
      e_st = (streak == 0) ? 2'd0 : (streak <= SC) ? 2'd1 : 2'd2;
      q.push_back({e_ce, e_half, streak > SC, e_st, lost});
    end
  end

  logic [11:0] exp_v, got_v;
  initial forever begin
    @(negedge clk_sys);
    if (q.size() > 0) begin
      exp_v = q.pop_front();
      got_v = {ce, ce_half, sys_reset_n, seq_state, lost_lock};
      total++;
      if (got_v === exp_v) passed++;
      else $display("FAIL scoreboard t=%0t got=%h expected=%h (ce,ce_half,sys_reset_n,seq_state,lost_lock)", $time, got_v, exp_v);
    end
  end

  task automatic chk_zero(input string nm);
    total++;
    if ({ce, ce_half, sys_reset_n, seq_state, lost_lock} === 12'h0) passed++;
    else $display("FAIL %s got=%h expected=000", nm, {ce, ce_half, sys_reset_n, seq_state, lost_lock});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  int drop, idx, pick;
  logic [W-1:0] v;
  initial begin
    cyc(3);
    #1 chk_zero("reset_state");
    cyc(1);
    rst_n = 1'b1;
    ch_inc = {16'd65535, 16'd0, 16'd24576, 16'd16384};
    ch_en = '1;
    cyc(2);
    pll_locked = 1'b1;
    cyc(60);
    ch_en[1] = 1'b0;
    cyc(5);
    ch_en[1] = 1'b1;
    cyc(20);
    ch_inc[W +: W] = 16'd5000;
    cyc(20);
    pll_locked = 1'b0;
    cyc(8);
    pll_locked = 1'b1;
    cyc(25);
    lost_lock_clr = 1'b1;
    cyc(1);
    lost_lock_clr = 1'b0;
    cyc(5);
    for (int c = 0; c < N; c++) ch_inc[c*W +: W] = W'($urandom);
    cyc(30);
    lost_lock_clr = 1'b1;
    pll_locked = 1'b0;
    cyc(3);
    lost_lock_clr = 1'b0;
    cyc(3);
    pll_locked = 1'b1;
    cyc(25);
    drop = 0;
    for (int k = 0; k < 400; k++) begin
      cyc(1);
      lost_lock_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) begin
        idx = $urandom_range(0, N-1);
        ch_en[idx] = ~ch_en[idx];
      end
      if ($urandom_range(0, 29) == 0) begin
        idx = $urandom_range(0, N-1);
        pick = $urandom_range(0, 4);
        v = (pick == 0) ? 16'd0 : (pick == 1) ? 16'd65535 : (pick == 2) ? 16'd16384 :
            (pick == 3) ? 16'd24576 : W'($urandom);
        ch_inc[idx*W +: W] = v;
      end
      if (drop > 0) begin
        drop--;
        if (drop == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        pll_locked = 1'b0;
        drop = $urandom_range(1, 6);
      end
    end
    pll_locked = 1'b1;
    cyc(30);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    cyc(2);
    rst_n = 1'b1;
    cyc(30);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
